pipe_feeder: RTL and testbench

Byte-stream framer that feeds the MAC pipeline input (A, B, C, Ae, Be, save).
- Accepts a byte-wide valid/ready stream from the chip IO.
- Assembles one header byte, A, B and C (little-endian bytes) into a frame.
- Presents each frame as one registered, valid/ready-qualified operand word at the pipeline head.
- Double-buffered: the next frame assembles while the previous one waits for the consumer.

---
 rtl/pipe_feeder.sv | 139 +++++++++++++
 tb/tb_pipe_feeder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_feeder.sv
// rtl/pipe_feeder.sv - byte-stream framer feeding the MAC pipeline head (A, B, C, Ae, Be, save).
// Optional header sync check enabled by defining PIPE_FEEDER_HDR_CHECK_EN.
module pipe_feeder #(
  parameter int         CW       = 16,
  parameter logic [4:0] HDR_SYNC = 5'b10100
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [7:0]    out_a,
  output logic [7:0]    out_b,
  output logic [CW-1:0] out_c,
  output logic          out_ae,
  output logic          out_be,
  output logic          out_save,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    frame_cnt,
  output logic          hdr_err
);
  localparam int         NC      = CW / 8;
  localparam logic [2:0] ST_HDR  = 3'd0;
  localparam logic [2:0] ST_A    = 3'd1;
  localparam logic [2:0] ST_B    = 3'd2;
  localparam logic [2:0] ST_LAST = 3'(2 + NC);

  logic [2:0]    state, state_nxt;
  logic          acc, last, hdr_ok, handoff;
  logic [7:0]    a_q, b_q;
  logic [CW-1:0] c_q, c_nxt;
  logic          ae_q, be_q, save_q;

  assign last    = (state == ST_LAST);
  assign acc     = in_valid && in_ready;
  assign handoff = out_valid && out_ready;

`ifdef PIPE_FEEDER_HDR_CHECK_EN
  assign hdr_ok = (in_data[7:3] == HDR_SYNC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      hdr_err <= 1'b0;
    else if (acc && state == ST_HDR && !hdr_ok)
      hdr_err <= 1'b1;
  end
`else
  logic unused_sync;
  assign unused_sync = ^HDR_SYNC;
  assign hdr_ok      = 1'b1;
  assign hdr_err     = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= ST_HDR;
    else
      state <= state_nxt;
  end

  // A rejected header is consumed but leaves the FSM in HDR so the stream resyncs.
  always_comb begin
    state_nxt = state;
    if (acc) begin
      if (last || (state == ST_HDR && !hdr_ok))
        state_nxt = ST_HDR;
      else
        state_nxt = state + 3'd1;
    end
  end

  always_comb begin
    in_ready = 1'b1;
    if (last)
      in_ready = !out_valid || out_ready;
  end

  // Merge the incoming byte into its little-endian slot of C.
  always_comb begin
    c_nxt = c_q;
    for (int i = 0; i < NC; i++) begin
      if (state == 3'(3 + i))
        c_nxt[8*i +: 8] = in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= '0;
      ae_q   <= 1'b0;
      be_q   <= 1'b0;
      save_q <= 1'b0;
    end else if (acc) begin
      case (state)
        ST_HDR: begin
          ae_q   <= in_data[0];
          be_q   <= in_data[1];
          save_q <= in_data[2];
        end
        ST_A:    a_q <= in_data;
        ST_B:    b_q <= in_data;
        default: c_q <= c_nxt;
      endcase
    end
  end

  // Hold stage: loads only when empty or draining, so data is stable under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_a     <= '0;
      out_b     <= '0;
      out_c     <= '0;
      out_ae    <= 1'b0;
      out_be    <= 1'b0;
      out_save  <= 1'b0;
      out_valid <= 1'b0;
    end else if (acc && last) begin
      out_a     <= a_q;
      out_b     <= b_q;
      out_c     <= c_nxt;
      out_ae    <= ae_q;
      out_be    <= be_q;
      out_save  <= save_q;
      out_valid <= 1'b1;
    end else if (handoff) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      frame_cnt <= '0;
    else if (handoff)
      frame_cnt <= frame_cnt + 8'd1;
  end
endmodule

// File: tb/tb_pipe_feeder.sv
// tb/tb_pipe_feeder.sv - directed and randomized checks of pipe_feeder against a frame-level model.
module tb_pipe_feeder;
  localparam int CW = 16;
  localparam int FL = 3 + CW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    out_a, out_b;
  logic [CW-1:0] out_c;
  logic          out_ae, out_be, out_save, out_valid, out_ready;
  logic [7:0]    frame_cnt;
  logic          hdr_err;

  pipe_feeder #(.CW(CW), .HDR_SYNC(5'b10100)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_ae(out_ae), .out_be(out_be),
    .out_save(out_save), .out_valid(out_valid), .out_ready(out_ready),
    .frame_cnt(frame_cnt), .hdr_err(hdr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]    a;
    logic [7:0]    b;
    logic [CW-1:0] c;
    logic          ae;
    logic          be;
    logic          save;
  } frame_t;

  frame_t     fq[$];
  logic [7:0] bq[$];
  logic [7:0] exp_cnt;
  logic       exp_err;
  int         checks   = 0;
  int         failures = 0;
  logic       acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    bq.delete();
    fq.delete();
    exp_cnt = 8'd0;
    exp_err = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] d);
    frame_t f;
    bq.push_back(d);
`ifdef PIPE_FEEDER_HDR_CHECK_EN
    if (bq.size() == 1 && d[7:3] != 5'b10100) begin
      bq.delete();
      exp_err = 1'b1;
      return;
    end
`endif
    if (bq.size() == FL) begin
      f.ae   = bq[0][0];
      f.be   = bq[0][1];
      f.save = bq[0][2];
      f.a    = bq[1];
      f.b    = bq[2];
      f.c    = '0;
      for (int i = 0; i < CW / 8; i++)
        f.c = f.c | (CW'(bq[3+i]) << (8 * i));
      fq.push_back(f);
      bq.delete();
    end
  endtask

  task automatic cyc(input logic v, input logic [7:0] d, input logic r, output logic accepted);
    logic ev, er, ho;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    #1;
    ev = (fq.size() != 0);
    er = (bq.size() != FL - 1) || !ev || r;
    chk("in_ready", 32'(in_ready), 32'(er));
    chk("out_valid", 32'(out_valid), 32'(ev));
    if (ev && r) begin
      chk("out_a", 32'(out_a), 32'(fq[0].a));
      chk("out_b", 32'(out_b), 32'(fq[0].b));
      chk("out_c", 32'(out_c), 32'(fq[0].c));
      chk("flags", {29'd0, out_save, out_be, out_ae}, {29'd0, fq[0].save, fq[0].be, fq[0].ae});
    end
    accepted = v && er;
    ho = ev && r;
    @(posedge clk);
    if (ho) begin
      void'(fq.pop_front());
      exp_cnt++;
    end
    if (accepted)
      model_byte(d);
    #1;
    chk("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
    chk("hdr_err", 32'(hdr_err), 32'(exp_err));
  endtask

  task automatic send_byte(input logic [7:0] d, input logic r);
    logic a = 1'b0;
    int   n = 0;
    while (!a && n < 40) begin
      cyc(1'b1, d, r, a);
      n++;
    end
    if (!a)
      chk("send_timeout", 32'(a), 32'd1);
  endtask

  task automatic check_zero(input string tag);
    chk(tag, {out_a, out_b, out_c}, 32'd0);
    chk({tag, "_flags"}, {26'd0, out_ae, out_be, out_save, out_valid, hdr_err, |frame_cnt}, 32'd0);
  endtask

  task automatic send_rand_frame(input bit rand_ready, input int gap_pct);
    logic [7:0] fr[FL];
    logic       a;
    int         n;
    fr[0] = {5'b10100, 3'($urandom_range(0, 7))};
    for (int i = 1; i < FL; i++)
      fr[i] = 8'($urandom);
    for (int i = 0; i < FL; i++) begin
      a = 1'b0;
      n = 0;
      while (!a && n < 200) begin
        cyc(($urandom_range(0, 99) >= gap_pct), fr[i],
            rand_ready ? 1'($urandom_range(0, 1)) : 1'b1, a);
        n++;
      end
      if (!a)
        chk("rand_timeout", 32'(a), 32'd1);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    // Single frame, no gaps
    send_byte(8'hA4, 1'b1);
    send_byte(8'h3C, 1'b1);
    send_byte(8'hC5, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h12, 1'b1);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_a", 32'(out_a), 32'h3C);
    chk("t1_b", 32'(out_b), 32'hC5);
    chk("t1_c", 32'(out_c), 32'h1234);
    chk("t1_flags", {29'd0, out_save, out_be, out_ae}, 32'b100);
    cyc(1'b0, 8'h00, 1'b1, acc);
    chk("t1_cnt", 32'(frame_cnt), 32'd1);

    // Backpressure with two back-to-back frames
    send_byte(8'hA5, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h04, 1'b0);
    send_byte(8'hA6, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    repeat (2) begin
      cyc(1'b1, 8'h44, 1'b0, acc);
      chk("t2_stall", 32'(acc), 32'd0);
      chk("t2_hold_a", 32'(out_a), 32'h01);
      chk("t2_hold_c", 32'(out_c), 32'h0403);
    end
    cyc(1'b1, 8'h44, 1'b1, acc);
    chk("t2_load", 32'(acc), 32'd1);
    chk("t2_valid", 32'(out_valid), 32'd1);
    chk("t2_a", 32'(out_a), 32'h11);
    chk("t2_c", 32'(out_c), 32'h4433);
    chk("t2_flags", {29'd0, out_save, out_be, out_ae}, 32'b110);
    cyc(1'b0, 8'h00, 1'b0, acc);
    chk("t2_ready", 32'(in_ready), 32'd1);
    cyc(1'b0, 8'h00, 1'b1, acc);
    chk("t2_cnt", 32'(frame_cnt), 32'd3);

    // Stream gaps every other cycle
    cyc(1'b0, 8'h00, 1'b1, acc); send_byte(8'hA4, 1'b1);
    cyc(1'b0, 8'h00, 1'b1, acc); send_byte(8'h3C, 1'b1);
    cyc(1'b0, 8'h00, 1'b1, acc); send_byte(8'hC5, 1'b1);
    cyc(1'b0, 8'h00, 1'b1, acc); send_byte(8'h34, 1'b1);
    cyc(1'b0, 8'h00, 1'b1, acc); send_byte(8'h12, 1'b1);
    chk("t3_valid", 32'(out_valid), 32'd1);
    chk("t3_c", 32'(out_c), 32'h1234);
    cyc(1'b0, 8'h00, 1'b1, acc);

    // Reset mid-frame
    send_byte(8'hA7, 1'b1);
    send_byte(8'h55, 1'b1);
    send_byte(8'h66, 1'b1);
    rst = 1'b1;
    model_reset();
    #1;
    check_zero("t4_rst_async");
    @(posedge clk);
    #1;
    check_zero("t4_rst_held");
    rst = 1'b0;
    send_byte(8'hA4, 1'b1);
    send_byte(8'h3C, 1'b1);
    send_byte(8'hC5, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h12, 1'b1);
    chk("t4_a", 32'(out_a), 32'h3C);
    chk("t4_c", 32'(out_c), 32'h1234);
    cyc(1'b0, 8'h00, 1'b1, acc);
    chk("t4_cnt", 32'(frame_cnt), 32'd1);

    // Random valid/ready traffic
    for (int f = 0; f < 30; f++)
      send_rand_frame(1'b1, 30);
    repeat (3) cyc(1'b0, 8'h00, 1'b1, acc);

    // Counter wrap after 256 handoffs from reset
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int f = 0; f < 256; f++)
      send_rand_frame(1'b0, 25);
    repeat (2) cyc(1'b0, 8'h00, 1'b1, acc);
    chk("t5_wrap", 32'(frame_cnt), 32'd0);

    // Bad header followed by a valid frame
    send_byte(8'hFF, 1'b1);
    send_byte(8'hA7, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
`ifdef PIPE_FEEDER_HDR_CHECK_EN
    chk("t6_hdr_err", 32'(hdr_err), 32'd1);
    chk("t6_valid", 32'(out_valid), 32'd1);
    chk("t6_flags", {29'd0, out_save, out_be, out_ae}, 32'b111);
    chk("t6_c", 32'(out_c), 32'h4433);
`else
    chk("t6_hdr_err", 32'(hdr_err), 32'd0);
`endif
    repeat (2) cyc(1'b0, 8'h00, 1'b1, acc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
